// File: rtl/ddr_input_pkg.sv
// ---------------------------------------------------------------------------
// ddr_input_pkg
// Shared constants and a helper for the DDR input deserializer tile.
//   DATA_W         width of the observed output word
//   BITS_PER_CYCLE samples captured per clk cycle (one per edge)
//   SER_BIT        position of the serial data bit within ui_in
// Optional build macro used by the sampler: DDR_INPUT_SYNC_EN.
// ---------------------------------------------------------------------------
package ddr_input_pkg;

    localparam int DATA_W         = 8;
    localparam int BITS_PER_CYCLE = 2;
    localparam int SER_BIT        = 0;

    // Shift one captured pair into the low end of the word; the oldest pair
    // falls off the top.
    function automatic logic [DATA_W-1:0] shift_in_pair(
        input logic [DATA_W-1:0]         word,
        input logic [BITS_PER_CYCLE-1:0] pair
    );
        return {word[DATA_W-BITS_PER_CYCLE-1:0], pair};
    endfunction

endpackage

// File: rtl/ddr_input_deserializer_if.sv
// ---------------------------------------------------------------------------
// ddr_input_deserializer_if
// Tiny Tapeout tile pin bundle (everything except clk and rst_n).
//   ena      tile enable
//   ui_in    dedicated inputs, bit 0 carries the DDR serial stream
//   uo_out   dedicated outputs, deserialized word
//   uio_in   bidirectional pins, input side
//   uio_out  bidirectional pins, output side
//   uio_oe   bidirectional pins, output enables
// Modports: master = pad/harness side, slave = the tile design.
// ---------------------------------------------------------------------------
interface ddr_input_deserializer_if;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );

endinterface

// File: rtl/ddr_edge_sampler.sv
// ---------------------------------------------------------------------------
// ddr_edge_sampler
// Captures one serial input on both clock edges.
//   clk     sample clock, both edges used
//   rst_n   asynchronous active-low reset, clears every flop to 0
//   d       serial data input
//   rise_q  sample taken on the rising edge (posedge domain)
//   fall_q  sample taken on the falling edge (negedge domain)
// Macro DDR_INPUT_SYNC_EN: when defined, each path gets a second flop on the
// same edge as a metastability guard, adding exactly one clk cycle of latency
// to both paths so the bit order is preserved.
// ---------------------------------------------------------------------------
module ddr_edge_sampler (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise_q,
    output logic fall_q
);

`ifdef DDR_INPUT_SYNC_EN

    logic rise_meta;
    logic fall_meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_meta <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            rise_meta <= d;
            rise_q    <= rise_meta;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fall_meta <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            fall_meta <= d;
            fall_q    <= fall_meta;
        end
    end

`else

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
        end else begin
            rise_q <= d;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= d;
        end
    end

`endif

endmodule

// File: rtl/ddr_input_deserializer.sv
// ---------------------------------------------------------------------------
// ddr_input_deserializer
// Tiny Tapeout tile: DDR capture of ui_in[0], packing the last 8 captured
// bits into uo_out (bit 0 newest, bit 7 oldest).
//   clk     single clock; both edges sample data
//   rst_n   asynchronous active-low reset
//   tt      tile pin bundle (slave modport):
//             ena      ignored, the design is always active
//             ui_in    bit 0 serial data, bits 7:1 unused
//             uo_out   deserialized word, registered
//             uio_in   unused
//             uio_out  tied 8'h00
//             uio_oe   tied 8'h00 (all uio pins are inputs)
// Optional macro DDR_INPUT_SYNC_EN adds a metastability stage in the sampler.
// ---------------------------------------------------------------------------
module ddr_input_deserializer
    import ddr_input_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    ddr_input_deserializer_if.slave  tt
);

    logic              rise_q;
    logic              fall_q;
    logic [DATA_W-1:0] sr;

    ddr_edge_sampler u_sampler (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (tt.ui_in[SER_BIT]),
        .rise_q (rise_q),
        .fall_q (fall_q)
    );

    // rise_q is the older sample of the pair (previous posedge) and fall_q
    // the newer one (the negedge after it), so fall_q lands in bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= shift_in_pair(sr, {rise_q, fall_q});
        end
    end

    assign tt.uo_out  = sr;
    assign tt.uio_out = 8'h00;
    assign tt.uio_oe  = 8'h00;

    // Tile pins the design deliberately ignores.
    logic unused_pins;
    assign unused_pins = &{1'b0, tt.ena, tt.uio_in, tt.ui_in};

endmodule

// File: tb/tb_ddr_input_deserializer.sv
// ---------------------------------------------------------------------------
// tb_ddr_input_deserializer
// Self-checking bench for ddr_input_deserializer. Data is driven a quarter
// period after each clk edge; outputs are sampled 1 time unit after posedge.
// The reference model keeps the chronological list of bits sampled at every
// clk edge (0 while in reset) and expects uo_out to be the last 8 of them,
// excluding the samples still in flight inside the sampler.
// ---------------------------------------------------------------------------
module tb_ddr_input_deserializer;

    localparam int HALF = 10;

`ifdef DDR_INPUT_SYNC_EN
    localparam int SKIP = 3;
`else
    localparam int SKIP = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ddr_input_deserializer_if tt ();

    ddr_input_deserializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tt    (tt)
    );

    always #HALF clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit hist[$];

    typedef struct {
        bit         r;
        bit         f;
        logic [7:0] exp;
        logic [7:0] exp_sync;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %02h, expected %02h", name, $time, act, exp);
        end
    endtask

    task automatic push(input bit b);
        hist.push_back(rst_n ? b : 1'b0);
    endtask

    function automatic logic [7:0] model_word();
        logic [7:0] w;
        int         idx;
        w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            idx = hist.size() - 1 - SKIP - i;
            if (idx >= 0) w[i] = hist[idx];
        end
        return w;
    endfunction

    // Entered at posedge+1: drive the bit for the coming negedge, then the
    // bit for the following posedge, and return at that posedge+1.
    task automatic cycle(input bit r, input bit f);
        #(HALF/2 - 1);
        tt.ui_in = {7'b0, f};
        push(f);
        @(negedge clk);
        #(HALF/2);
        tt.ui_in = {7'b0, r};
        push(r);
        @(posedge clk);
        #1;
    endtask

    // Same as cycle, but rst_n is released in the low phase so the coming
    // posedge is the first one to capture data.
    task automatic release_cycle(input bit r);
        #(HALF/2 - 1);
        tt.ui_in = 8'h00;
        push(1'b0);
        @(negedge clk);
        #(HALF/2);
        rst_n    = 1'b1;
        tt.ui_in = {7'b0, r};
        push(r);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] lfsr_step(input logic [4:0] l);
        return {l[3:0], ~(l[4] ^ l[2])};
    endfunction

    logic [4:0] lfsr;
    bit         rb;
    bit         fb;

    initial begin
        // Post-release sequence: constant 1, then rise=1/fall=0, then rise=0/fall=1.
        tbl[0]  = '{1'b1, 1'b1, 8'h03, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 8'h0F, 8'h03};
        tbl[2]  = '{1'b1, 1'b1, 8'h3F, 8'h0F};
        tbl[3]  = '{1'b1, 1'b1, 8'hFF, 8'h3F};
        tbl[4]  = '{1'b1, 1'b1, 8'hFF, 8'hFF};
        tbl[5]  = '{1'b1, 1'b0, 8'hFE, 8'hFF};
        tbl[6]  = '{1'b1, 1'b0, 8'hFA, 8'hFE};
        tbl[7]  = '{1'b1, 1'b0, 8'hEA, 8'hFA};
        tbl[8]  = '{1'b1, 1'b0, 8'hAA, 8'hEA};
        tbl[9]  = '{1'b1, 1'b0, 8'hAA, 8'hAA};
        tbl[10] = '{1'b0, 1'b1, 8'hAB, 8'hAA};
        tbl[11] = '{1'b0, 1'b1, 8'hAD, 8'hAB};
        tbl[12] = '{1'b0, 1'b1, 8'hB5, 8'hAD};
        tbl[13] = '{1'b0, 1'b1, 8'hD5, 8'hB5};
        tbl[14] = '{1'b0, 1'b1, 8'h55, 8'hD5};
        tbl[15] = '{1'b0, 1'b1, 8'h55, 8'h55};

        tt.ena    = 1'b1;
        tt.ui_in  = 8'h00;
        tt.uio_in = 8'h00;
        rst_n     = 1'b0;

        // Reset held for two cycles.
        @(posedge clk);
        #1;
        check("reset_uo", tt.uo_out, 8'h00);
        check("reset_uio_oe", tt.uio_oe, 8'h00);
        check("reset_uio_out", tt.uio_out, 8'h00);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1);
            check("reset_held_uo", tt.uo_out, 8'h00);
        end
        release_cycle(1'b1);
        check("release_uo", tt.uo_out, 8'h00);

        // Table-driven fill and saturation patterns.
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].r, tbl[i].f);
`ifdef DDR_INPUT_SYNC_EN
            check($sformatf("tbl_%0d", i), tt.uo_out, tbl[i].exp_sync);
`else
            check($sformatf("tbl_%0d", i), tt.uo_out, tbl[i].exp);
`endif
        end

        // Mid-stream reset with the word at 8'hAA.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
        check("pre_reset_aa", tt.uo_out, 8'hAA);
        rst_n = 1'b0;
        hist.delete();
        #1;
        check("reset_immediate", tt.uo_out, 8'h00);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0);
            check("mid_reset_held", tt.uo_out, 8'h00);
        end

        // Release, then a seed-0 XNOR LFSR, one bit per half-cycle.
        lfsr = 5'd0;
        lfsr = lfsr_step(lfsr);
        release_cycle(lfsr[0]);
        check("mid_release_uo", tt.uo_out, model_word());
        for (int i = 0; i < 200; i++) begin
            lfsr = lfsr_step(lfsr);
            fb   = lfsr[0];
            lfsr = lfsr_step(lfsr);
            rb   = lfsr[0];
            cycle(rb, fb);
            check($sformatf("lfsr_%0d", i), tt.uo_out, model_word());
        end

        // Random stream.
        for (int i = 0; i < 100; i++) begin
            rb = 1'($urandom_range(0, 1));
            fb = 1'($urandom_range(0, 1));
            cycle(rb, fb);
            check($sformatf("rand_%0d", i), tt.uo_out, model_word());
        end

        check("end_uio_oe", tt.uio_oe, 8'h00);
        check("end_uio_out", tt.uio_out, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
